cdb_arbiter: RTL and testbench

- Transmit end of the Common Data Bus (CDB). The reservation station dispatches to the sum/sub ALU and the load/store unit; this block collects their results and drives the 16-bit CDB the station samples.
- Buffers each producer in its own small FIFO, arbitrates round-robin and packs the CDB word.
- Emits at most one word per cycle and drives all-zero when idle.

---
 rtl/cdb_pkg.sv | 52 +++++
 rtl/cdb_fifo.sv | 70 +++++++
 rtl/cdb_arbiter.sv | 174 +++++++++++++++++
 tb/tb_cdb_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdb_pkg
// Purpose  : Shared definitions for the CDB transmit arbiter: bus field
//            layout, source-bit encoding, arbiter state encoding and the
//            destination-register decoder.
// Revision : 1.0 - initial release
// ============================================================================
package cdb_pkg;

    // Packed CDB word layout: {dest_onehot[2:0], pos[1:0], src, data[9:0]}
    localparam int CDB_W        = 16;
    localparam int CDB_DATA_LSB = 0;
    localparam int CDB_DATA_W   = 10;
    localparam int CDB_SRC_BIT  = 10;
    localparam int CDB_POS_LSB  = 11;
    localparam int CDB_POS_W    = 2;
    localparam int CDB_DEST_LSB = 13;
    localparam int CDB_DEST_W   = 3;

    localparam logic CDB_SRC_ALU = 1'b1;
    localparam logic CDB_SRC_LS  = 1'b0;

    // State records which kind of word was driven on the bus this cycle.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ALU     = 2'd1,
        S_LS_ADDR = 2'd2,
        S_LS_DATA = 2'd3
    } cdb_state_t;

    typedef struct packed {
        logic                  illegal;
        logic [CDB_DEST_W-1:0] onehot;
    } dest_dec_t;

    // R0 maps to the MSB of the dest field; encodings 3..7 are illegal.
    function automatic dest_dec_t dest_to_onehot(input logic [2:0] dest);
        dest_dec_t d;
        d.illegal = 1'b0;
        d.onehot  = '0;
        case (dest)
            3'd0:    d.onehot = 3'b100;
            3'd1:    d.onehot = 3'b010;
            3'd2:    d.onehot = 3'b001;
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cdb_fifo
// Purpose  : Small synchronous FIFO buffering one CDB producer.
// Ports    : clock, reset (async active-low), push, pop, din,
//            full, empty, head (combinational view of the oldest entry).
//            Push is refused when full even if a pop happens in the same
//            cycle; pop on empty is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign full   = (r_count == c_CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign head   = r_mem[r_rd_ptr];

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Purpose  : Transmit end of the Common Data Bus. Buffers ALU and load/store
//            results in per-producer FIFOs, arbitrates round-robin (with LS
//            address/data pair completion) and drives one registered 16-bit
//            CDB word per cycle, all-zero when idle.
// Ports    : clock, reset (async active-low)
//            alu_valid/alu_ready/alu_dest/alu_pos/alu_data   - ALU producer
//            ls_valid/ls_ready/ls_dest/ls_pos/ls_data/ls_last - LS producer
//            cdb      - packed bus word, 0 = no event
//            err_dest - pulse: word with illegal dest dropped
//            err_beat - pulse: LS beat-order violation
// Config   : define CDB_BEAT_CHECK_EN to build the LS beat-order checker;
//            otherwise err_beat is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int DATA_W     = CDB_DATA_W,
    parameter int POS_W      = CDB_POS_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [2:0]        alu_dest,
    input  logic [POS_W-1:0]  alu_pos,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ls_valid,
    output logic              ls_ready,
    input  logic [2:0]        ls_dest,
    input  logic [POS_W-1:0]  ls_pos,
    input  logic [DATA_W-1:0] ls_data,
    input  logic              ls_last,
    output logic [CDB_W-1:0]  cdb,
    output logic              err_dest,
    output logic              err_beat
);

    localparam int c_ALU_W = 3 + POS_W + DATA_W;
    localparam int c_LS_W  = c_ALU_W + 1;

    logic                w_alu_full, w_alu_empty, w_alu_push, w_alu_pop;
    logic                w_ls_full,  w_ls_empty,  w_ls_push,  w_ls_pop;
    logic [c_ALU_W-1:0]  w_alu_head;
    logic [c_LS_W-1:0]   w_ls_head;
    dest_dec_t           w_alu_dec, w_ls_dec;
    logic                w_ls_head_last;

    cdb_state_t          r_state, w_state_nxt;
    logic [CDB_W-1:0]    r_cdb, w_cdb_nxt;
    logic                r_err_dest, w_err_dest_nxt;
    logic                r_rr_alu, w_rr_alu_nxt;   // 1 = ALU preferred on tie

    assign alu_ready  = ~w_alu_full;
    assign ls_ready   = ~w_ls_full;
    assign w_alu_push = alu_valid & ~w_alu_full;
    assign w_ls_push  = ls_valid & ~w_ls_full;

    cdb_fifo #(.WIDTH(c_ALU_W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_alu_push),
        .pop   (w_alu_pop),
        .din   ({alu_dest, alu_pos, alu_data}),
        .full  (w_alu_full),
        .empty (w_alu_empty),
        .head  (w_alu_head)
    );

    cdb_fifo #(.WIDTH(c_LS_W), .DEPTH(FIFO_DEPTH)) u_ls_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_ls_push),
        .pop   (w_ls_pop),
        .din   ({ls_last, ls_dest, ls_pos, ls_data}),
        .full  (w_ls_full),
        .empty (w_ls_empty),
        .head  (w_ls_head)
    );

    assign w_alu_dec      = dest_to_onehot(w_alu_head[DATA_W+POS_W +: 3]);
    assign w_ls_dec       = dest_to_onehot(w_ls_head[DATA_W+POS_W +: 3]);
    assign w_ls_head_last = w_ls_head[c_LS_W-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cdb      <= '0;
            r_err_dest <= 1'b0;
            r_rr_alu   <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cdb      <= w_cdb_nxt;
            r_err_dest <= w_err_dest_nxt;
            r_rr_alu   <= w_rr_alu_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = S_IDLE;
        w_cdb_nxt      = '0;
        w_err_dest_nxt = 1'b0;
        w_rr_alu_nxt   = r_rr_alu;
        w_alu_pop      = 1'b0;
        w_ls_pop       = 1'b0;

        // Pair completion: the data beat right after an address beat wins.
        if (r_state == S_LS_ADDR && !w_ls_empty && w_ls_head_last) begin
            w_ls_pop = 1'b1;
        end else if (!w_alu_empty && !w_ls_empty) begin
            w_alu_pop = r_rr_alu;
            w_ls_pop  = ~r_rr_alu;
        end else begin
            w_alu_pop = ~w_alu_empty;
            w_ls_pop  = ~w_ls_empty;
        end

        if (w_alu_pop) begin
            w_rr_alu_nxt = 1'b0;
            if (w_alu_dec.illegal) begin
                w_err_dest_nxt = 1'b1;
            end else begin
                w_state_nxt = S_ALU;
                w_cdb_nxt[CDB_DEST_LSB +: CDB_DEST_W] = w_alu_dec.onehot;
                w_cdb_nxt[CDB_POS_LSB +: POS_W]       = w_alu_head[DATA_W +: POS_W];
                w_cdb_nxt[CDB_SRC_BIT]                = CDB_SRC_ALU;
                w_cdb_nxt[CDB_DATA_LSB +: DATA_W]     = w_alu_head[DATA_W-1:0];
            end
        end else if (w_ls_pop) begin
            w_rr_alu_nxt = 1'b1;
            if (w_ls_dec.illegal) begin
                w_err_dest_nxt = 1'b1;
            end else begin
                w_state_nxt = w_ls_head_last ? S_LS_DATA : S_LS_ADDR;
                w_cdb_nxt[CDB_DEST_LSB +: CDB_DEST_W] = w_ls_dec.onehot;
                w_cdb_nxt[CDB_POS_LSB +: POS_W]       = w_ls_head[DATA_W +: POS_W];
                w_cdb_nxt[CDB_SRC_BIT]                = CDB_SRC_LS;
                w_cdb_nxt[CDB_DATA_LSB +: DATA_W]     = w_ls_head[DATA_W-1:0];
            end
        end
    end

    assign cdb      = r_cdb;
    assign err_dest = r_err_dest;

`ifdef CDB_BEAT_CHECK_EN
    // LS beats must alternate address (last=0) / data (last=1). A wrong
    // beat is flagged but still enqueued.
    logic r_exp_last;
    logic r_err_beat;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_exp_last <= 1'b0;
            r_err_beat <= 1'b0;
        end else begin
            r_err_beat <= w_ls_push && (ls_last != r_exp_last);
            if (w_ls_push) begin
                r_exp_last <= ~r_exp_last;
            end
        end
    end

    assign err_beat = r_err_beat;
`else
    assign err_beat = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Purpose  : Directed self-checking bench for cdb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    logic        clock;
    logic        reset;
    logic        alu_valid, alu_ready;
    logic [2:0]  alu_dest;
    logic [1:0]  alu_pos;
    logic [9:0]  alu_data;
    logic        ls_valid, ls_ready;
    logic [2:0]  ls_dest;
    logic [1:0]  ls_pos;
    logic [9:0]  ls_data;
    logic        ls_last;
    logic [15:0] cdb;
    logic        err_dest, err_beat;

    int n_cmp = 0;
    int n_err = 0;

`ifdef CDB_BEAT_CHECK_EN
    localparam logic c_EXP_BEAT_ERR = 1'b1;
`else
    localparam logic c_EXP_BEAT_ERR = 1'b0;
`endif

    cdb_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_dest  (alu_dest),
        .alu_pos   (alu_pos),
        .alu_data  (alu_data),
        .ls_valid  (ls_valid),
        .ls_ready  (ls_ready),
        .ls_dest   (ls_dest),
        .ls_pos    (ls_pos),
        .ls_data   (ls_data),
        .ls_last   (ls_last),
        .cdb       (cdb),
        .err_dest  (err_dest),
        .err_beat  (err_beat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_dest = 0; alu_pos = 0; alu_data = 0;
        ls_valid  = 0; ls_dest  = 0; ls_pos  = 0; ls_data  = 0; ls_last = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Both-FIFOs-full stream: expected per-cycle bus word and readies.
    logic [15:0] exp_cdb [10] = '{16'h0000, 16'h8500, 16'h2200, 16'h2A01, 16'h8D01,
                                  16'h3202, 16'h3A03, 16'h9502, 16'h9D03, 16'h0000};
    logic        exp_ar  [10] = '{1, 1, 0, 0, 1, 0, 0, 1, 1, 1};
    logic        exp_lr  [10] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};

    initial begin
        int ai, li;
        logic ap, lp;
        reset = 1'b1;
        idle_inputs();
        #1;
        apply_reset();

        // Reset state
        chk("rst_cdb", cdb, 0);
        chk("rst_alu_ready", alu_ready, 1);
        chk("rst_ls_ready", ls_ready, 1);
        chk("rst_err_dest", err_dest, 0);
        chk("rst_err_beat", err_beat, 0);

        // Single ALU word
        alu_valid = 1; alu_dest = 1; alu_pos = 2; alu_data = 10'h005;
        tick();
        alu_valid = 0;
        chk("alu1_lat", cdb, 0);
        tick();
        chk("alu1_word", cdb, 16'h5405);
        tick();
        chk("alu1_clear", cdb, 0);

        // LS address/data pair
        ls_valid = 1; ls_dest = 0; ls_pos = 0; ls_data = 10'h011; ls_last = 0;
        tick();
        ls_data = 10'h03A; ls_last = 1;
        tick();
        ls_valid = 0;
        chk("ls_addr", cdb, 16'h8011);
        tick();
        chk("ls_data", cdb, 16'h803A);
        tick();
        chk("ls_clear", cdb, 0);

        // Simultaneous push from reset: ALU first
        apply_reset();
        alu_valid = 1; alu_dest = 2; alu_pos = 1; alu_data = 10'h123;
        ls_valid  = 1; ls_dest  = 1; ls_pos  = 3; ls_data  = 10'h0AB; ls_last = 0;
        tick();
        idle_inputs();
        chk("both_lat", cdb, 0);
        tick();
        chk("both_alu", cdb, 16'h2D23);
        tick();
        chk("both_ls", cdb, 16'h58AB);
        tick();
        chk("both_clear", cdb, 0);

        // Saturated stream on both producers
        apply_reset();
        ai = 0; li = 0;
        for (int k = 0; k < 10; k++) begin
            alu_valid = (ai < 4);
            alu_dest  = 3'd0;
            alu_pos   = 2'(ai);
            alu_data  = 10'(32'h100 + ai);
            ls_valid  = (li < 4);
            ls_dest   = 3'd2;
            ls_pos    = 2'(li);
            ls_data   = 10'(32'h200 + li);
            ls_last   = 1'(li & 1);
            ap = alu_valid && alu_ready;
            lp = ls_valid && ls_ready;
            tick();
            if (ap) ai++;
            if (lp) li++;
            chk($sformatf("full_cdb[%0d]", k), cdb, exp_cdb[k]);
            chk($sformatf("full_alu_ready[%0d]", k), alu_ready, exp_ar[k]);
            chk($sformatf("full_ls_ready[%0d]", k), ls_ready, exp_lr[k]);
        end
        idle_inputs();
        chk("full_alu_accepted", ai, 4);
        chk("full_ls_accepted", li, 4);

        // Illegal destination dropped, next legal word unaffected
        alu_valid = 1; alu_dest = 3; alu_pos = 0; alu_data = 10'h055;
        tick();
        alu_dest = 0; alu_pos = 1; alu_data = 10'h007;
        tick();
        alu_valid = 0;
        chk("ill_cdb", cdb, 0);
        chk("ill_err", err_dest, 1);
        tick();
        chk("ill_next_cdb", cdb, 16'h8C07);
        chk("ill_err_clear", err_dest, 0);
        tick();
        chk("ill_clear", cdb, 0);

        // Reset mid-stream
        apply_reset();
        alu_valid = 1; alu_dest = 1; alu_pos = 0; alu_data = 10'h0F1;
        ls_valid  = 1; ls_dest  = 0; ls_pos  = 1; ls_data  = 10'h0E2; ls_last = 0;
        repeat (3) tick();
        chk("mid_pre_cdb", cdb, 16'h88E2);
        #2 reset = 1'b0;
        #1;
        chk("mid_async_cdb", cdb, 0);
        chk("mid_alu_ready", alu_ready, 1);
        chk("mid_ls_ready", ls_ready, 1);
        idle_inputs();
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("mid_post_cdb[%0d]", k), cdb, 0);
        end

        // Two LS address beats in a row
        ls_valid = 1; ls_dest = 0; ls_pos = 0; ls_data = 10'h001; ls_last = 0;
        tick();
        chk("beat_first", err_beat, 0);
        ls_data = 10'h002;
        tick();
        ls_valid = 0;
        chk("beat_err", err_beat, c_EXP_BEAT_ERR);
        chk("beat_w1", cdb, 16'h8001);
        tick();
        chk("beat_err_clear", err_beat, 0);
        chk("beat_w2", cdb, 16'h8002);
        tick();
        chk("beat_clear", cdb, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
